rr_arbiter_hold: RTL and testbench

Parametrised N-way round-robin arbiter with registered one-hot grant and a per-grant burst limit (tenure). A granted requester keeps the grant while its request stays high, up to MAX_HOLD consecutive cycles, then rotates to the next requester. It sits in front of shared resources (FIFO write ports, bus masters) in the cdc_fifo_arbiters subsystem.

---
 rtl/rr_arbiter_hold.sv | 128 ++++++++++++
 tb/tb_rr_arbiter_hold.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_hold.sv
// -----------------------------------------------------------------------------
// rr_arbiter_hold
//   N-way round-robin arbiter with a registered one-hot grant and a per-grant
//   burst limit. A granted requester keeps the grant while its request stays
//   high, for up to MAX_HOLD consecutive cycles. After that the grant rotates.
//   The search for the next winner starts just past the previous winner.
//
//   Optional feature (macro ARB_LOCK_EN): adds a lock input. When lock is high,
//   the current grant is held past its tenure limit for as long as the granted
//   request stays high.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   lock       in   (ARB_LOCK_EN only) hold the current grant
//   req        in   [N-1:0]     level-sensitive request vector
//   gnt        out  [N-1:0]     registered one-hot grant, zero when idle
//   gnt_idx    out  [IDX_W-1:0] binary index of the grant, zero when idle
//   gnt_valid  out              OR of gnt
// -----------------------------------------------------------------------------
module rr_arbiter_hold #(
  parameter  int N        = 8,
  parameter  int MAX_HOLD = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam logic [7:0]     HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IDX_W:0] N_W       = (IDX_W + 1)'(N);

  logic [N-1:0]     gnt_q,     gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic [7:0]       hold_q,    hold_d;

  logic             lock_w;
`ifdef ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  // Rotate the requests so that bit 0 is the requester at ptr. The first set
  // bit of the rotated vector is then the offset of the winner from ptr.
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;
  logic [IDX_W:0]   nxt;
  logic [IDX_W-1:0] win;
  logic             any_req;

  always_comb begin
    rot = N'({req, req} >> ptr_q);
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any_req = |req;
    // The sum is at most 2N-2, so one conditional subtract reduces it mod N.
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    win = sum[IDX_W-1:0];
    nxt = {1'b0, win} + (IDX_W + 1)'(1);
    if (nxt == N_W) nxt = '0;
  end

  logic under_lim;
  logic keep;

  always_comb begin
    under_lim = hold_q < HOLD_LAST;
    keep      = gnt_vld_q && req[gnt_idx_q] && (under_lim || lock_w);

    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;

    if (keep) begin
      // Under lock the counter saturates, so the tenure expires once lock drops.
      if (under_lim) hold_d = hold_q + 8'd1;
    end else if (any_req) begin
      gnt_d      = '0;
      gnt_d[win] = 1'b1;
      gnt_idx_d  = win;
      gnt_vld_d  = 1'b1;
      hold_d     = '0;
      ptr_d      = nxt[IDX_W-1:0];
    end else begin
      // Idle: drop the grant but keep ptr and hold_cnt.
      gnt_d     = '0;
      gnt_idx_d = '0;
      gnt_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter_hold
//   Runs two arbiters: N=8, MAX_HOLD=4 and N=5, MAX_HOLD=1. A tenure-level
//   model tracks the holder, the tenure length and the next start index for
//   each arbiter. Every cycle, each arbiter's outputs are compared with its
//   model. Directed sequences add hand-computed expectations on top.
// -----------------------------------------------------------------------------
module tb_rr_arbiter_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic [7:0] req8 = '0;
  logic [4:0] req5 = '0;

  logic [7:0] gnt8;
  logic [2:0] idx8;
  logic       vld8;
  logic [4:0] gnt5;
  logic [2:0] idx5;
  logic       vld5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_hold #(.N(8), .MAX_HOLD(4)) u_dut8 (
    .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req8), .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(vld8)
  );

  rr_arbiter_hold #(.N(5), .MAX_HOLD(1)) u_dut5 (
    .clk(clk), .rst(rst),
`ifdef ARB_LOCK_EN
    .lock(1'b0),
`endif
    .req(req5), .gnt(gnt5), .gnt_idx(idx5), .gnt_valid(vld5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tenure model: hold = index of the holder (-1 when idle), cnt = cycles
  // granted so far in this tenure, ptr = first index searched next time.
  function automatic void mstep(input int n, input int mh, input logic [7:0] r,
                                input bit lk, inout int hold, inout int cnt,
                                inout int ptr);
    if (hold >= 0 && r[hold] && (cnt < mh || lk)) begin
      if (cnt < mh) cnt++;
    end else begin
      int w;
      w = -1;
      for (int i = 0; i < n; i++)
        if (w < 0 && r[(ptr + i) % n]) w = (ptr + i) % n;
      if (w >= 0) begin
        hold = w;
        cnt  = 1;
        ptr  = (w + 1) % n;
      end else begin
        hold = -1;
      end
    end
  endfunction

  int h8 = -1, c8 = 0, p8 = 0;
  int h5 = -1, c5 = 0, p5 = 0;

  always @(posedge clk) begin
    if (rst) begin
      h8 = -1; c8 = 0; p8 = 0;
      h5 = -1; c5 = 0; p5 = 0;
    end else begin
      mstep(8, 4, req8, lock, h8, c8, p8);
      mstep(5, 1, {3'b000, req5}, 1'b0, h5, c5, p5);
    end
    #1;
    if (!rst) begin
      chk("m8_gnt", 64'(gnt8), (h8 < 0) ? 64'd0 : (64'd1 << h8));
      chk("m8_idx", 64'(idx8), (h8 < 0) ? 64'd0 : 64'(h8));
      chk("m8_vld", 64'(vld8), 64'(h8 >= 0));
      chk("m5_gnt", 64'(gnt5), (h5 < 0) ? 64'd0 : (64'd1 << h5));
      chk("m5_idx", 64'(idx5), (h5 < 0) ? 64'd0 : 64'(h5));
      chk("m5_vld", 64'(vld5), 64'(h5 >= 0));
    end
  end

  // Inputs change 2 time units after a rising edge. Checks read the
  // settled outputs at that same point.
  task automatic step(input logic [7:0] r8, input logic [4:0] r5);
    req8 = r8;
    req5 = r5;
    @(posedge clk);
    #2;
  endtask

  logic [7:0] pat;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 64'(gnt8), 64'd0);
    chk("rst_idx", 64'(idx8), 64'd0);
    chk("rst_vld", 64'(vld8), 64'd0);
    rst = 1'b0;

    // Full load: four cycles per requester, wrapping from 7 back to 0.
    for (int k = 0; k < 36; k++) begin
      step(8'hFF, 5'd0);
      pat = 8'd1 << ((k / 4) % 8);
      chk("ff_rotate", 64'(gnt8), 64'(pat));
      chk("ff_idx", 64'(idx8), 64'((k / 4) % 8));
    end

    // Move to a tenure of requester 2, then reset between edges.
    repeat (5) step(8'hFF, 5'd0);
    chk("pre_rst_gnt", 64'(gnt8), 64'h04);
    #3 rst = 1'b1;
    #1;
    chk("async_gnt", 64'(gnt8), 64'd0);
    chk("async_idx", 64'(idx8), 64'd0);
    chk("async_vld", 64'(vld8), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(8'hFF, 5'd0);
    chk("post_rst_first", 64'(gnt8), 64'h01);

    // A lone requester is re-granted at each tenure expiry, with no gap.
    for (int k = 0; k < 12; k++) begin
      step(8'h01, 5'd0);
      chk("solo_gnt", 64'(gnt8), 64'h01);
      chk("solo_vld", 64'(vld8), 64'd1);
    end
    step(8'h00, 5'd0);
    chk("idle_gnt", 64'(gnt8), 64'd0);
    chk("idle_vld", 64'(vld8), 64'd0);

    // Requester 1 drops its request early, then asserts it again. The next
    // tenure is not pre-empted.
    step(8'h06, 5'd0);
    chk("drop_g1a", 64'(gnt8), 64'h02);
    step(8'h06, 5'd0);
    chk("drop_g1b", 64'(gnt8), 64'h02);
    step(8'h04, 5'd0);
    chk("drop_move", 64'(gnt8), 64'h04);
    for (int k = 0; k < 3; k++) begin
      step(8'h06, 5'd0);
      chk("no_preempt", 64'(gnt8), 64'h04);
    end
    step(8'h06, 5'd0);
    chk("back_to_1", 64'(gnt8), 64'h02);

    // With MAX_HOLD=1 and N=5, the grant alternates between requesters 0
    // and 4. This exercises the wrap from 4 to 0.
    step(8'h00, 5'd0);
    for (int k = 0; k < 6; k++) begin
      step(8'h00, 5'b10001);
      chk("mh1_alt", 64'(gnt5), (k % 2 == 0) ? 64'h01 : 64'h10);
      chk("mh1_idx", 64'(idx5), (k % 2 == 0) ? 64'd0 : 64'd4);
    end
    step(8'h00, 5'd0);

`ifdef ARB_LOCK_EN
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    step(8'h03, 5'd0);
    chk("lock_first", 64'(gnt8), 64'h01);
    lock = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(8'h03, 5'd0);
      chk("lock_hold", 64'(gnt8), 64'h01);
    end
    lock = 1'b0;
    step(8'h03, 5'd0);
    chk("lock_release", 64'(gnt8), 64'h02);
`endif

    repeat (2) step(8'h00, 5'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
